// File: rtl/lcd_text_pkg.sv
// Shared definitions for the LCD text/attribute write path.
// Holds the command opcodes, controller states and default geometry.
package lcd_text_pkg;

  localparam int ADDR_W   = 10;
  localparam int DEF_COLS = 32;
  localparam int DEF_ROWS = 32;

  localparam logic [1:0] OP_SET_POS = 2'd0;
  localparam logic [1:0] OP_WRITE   = 2'd1;
  localparam logic [1:0] OP_FILL    = 2'd2;
  localparam logic [1:0] OP_NEWLINE = 2'd3;

  typedef enum logic [1:0] {
    INIT_FILL = 2'd0,
    IDLE      = 2'd1,
    FILL      = 2'd2
  } state_t;

endpackage

// File: rtl/attr_cursor.sv
// Text cursor: row, col and the matching linear address, kept in step without a divider.
// Priority is clear > set > increment > newline; only one is ever requested per cycle.
module attr_cursor
  import lcd_text_pkg::*;
#(
  parameter int COLS = DEF_COLS,
  parameter int ROWS = DEF_ROWS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              inc,
  input  logic              nl,
  input  logic              set,
  input  logic [4:0]        set_row,
  input  logic [4:0]        set_col,
  output logic [ADDR_W-1:0] cur_addr
);

  localparam logic [4:0]        ROW_MAX  = 5'(ROWS - 1);
  localparam logic [4:0]        COL_MAX  = 5'(COLS - 1);
  localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(COLS * ROWS - 1);
  localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);

  logic [4:0]        row, col;
  logic [4:0]        row_c, col_c;
  logic [ADDR_W-1:0] set_addr;

  always_comb begin
    row_c    = (set_row < ROW_MAX) ? set_row : ROW_MAX;
    col_c    = (set_col < COL_MAX) ? set_col : COL_MAX;
    set_addr = ADDR_W'(row_c * COLS) + ADDR_W'(col_c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row      <= '0;
      col      <= '0;
      cur_addr <= '0;
    end else if (clr) begin
      row      <= '0;
      col      <= '0;
      cur_addr <= '0;
    end else if (set) begin
      row      <= row_c;
      col      <= col_c;
      cur_addr <= set_addr;
    end else if (inc) begin
      if (col == COL_MAX) begin
        col <= '0;
        row <= (row == ROW_MAX) ? 5'd0 : row + 5'd1;
      end else begin
        col <= col + 5'd1;
      end
      cur_addr <= (cur_addr == ADDR_MAX) ? '0 : cur_addr + ADDR_W'(1);
    end else if (nl) begin
      col <= '0;
      if (row == ROW_MAX) begin
        row      <= '0;
        cur_addr <= '0;
      end else begin
        // Back up to column 0 of this row, then step one full row forward.
        row      <= row + 5'd1;
        cur_addr <= cur_addr - ADDR_W'(col) + COLS_A;
      end
    end
  end

endmodule

// File: rtl/attr_ram_writer.sv
// Write-side controller for the LCD attribute RAM: clears the screen after reset,
// then turns host commands (position, write, newline, fill) into registered RAM writes.
module attr_ram_writer
  import lcd_text_pkg::*;
#(
  parameter int         COLS      = DEF_COLS,
  parameter int         ROWS      = DEF_ROWS,
  parameter logic [7:0] INIT_ATTR = 8'h07
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [9:0]        cmd_data,
  output logic [ADDR_W-1:0] addr_w,
  output logic [7:0]        d,
  output logic              we,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(COLS * ROWS - 1);

  state_t            state, state_n;
  logic [ADDR_W-1:0] fill_addr, fill_addr_n, addr_n, cur_addr;
  logic [7:0]        fill_attr, fill_attr_n, d_n;
  logic              we_n, busy_n, ready_n;
  logic              cur_clr, cur_inc, cur_nl, cur_set;
  logic              accept;

  assign accept = cmd_valid && cmd_ready;

  always_comb begin
    state_n     = state;
    fill_addr_n = fill_addr;
    fill_attr_n = fill_attr;
    addr_n      = addr_w;
    d_n         = d;
    we_n        = 1'b0;
    busy_n      = busy;
    ready_n     = cmd_ready;
    cur_clr     = 1'b0;
    cur_inc     = 1'b0;
    cur_nl      = 1'b0;
    cur_set     = 1'b0;
    unique case (state)
      INIT_FILL, FILL: begin
        we_n    = 1'b1;
        addr_n  = fill_addr;
        d_n     = (state == FILL) ? fill_attr : INIT_ATTR;
        busy_n  = 1'b1;
        ready_n = 1'b0;
        if (fill_addr == LAST) begin
          state_n     = IDLE;
          fill_addr_n = '0;
          cur_clr     = 1'b1;
        end else begin
          fill_addr_n = fill_addr + ADDR_W'(1);
        end
      end
      IDLE: begin
        // busy/cmd_ready settle one cycle after the last fill write.
        busy_n  = 1'b0;
        ready_n = 1'b1;
        if (accept) begin
          case (cmd_op)
            OP_WRITE: begin
              we_n    = 1'b1;
              addr_n  = cur_addr;
              d_n     = cmd_data[7:0];
              cur_inc = 1'b1;
            end
            OP_SET_POS: cur_set = 1'b1;
            OP_NEWLINE: cur_nl  = 1'b1;
            OP_FILL: begin
              state_n     = FILL;
              fill_attr_n = cmd_data[7:0];
              fill_addr_n = '0;
              busy_n      = 1'b1;
              ready_n     = 1'b0;
            end
            default: ;
          endcase
        end
      end
      default: state_n = INIT_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT_FILL;
      fill_addr <= '0;
      fill_attr <= '0;
      we        <= 1'b0;
      addr_w    <= '0;
      d         <= '0;
      busy      <= 1'b1;
      cmd_ready <= 1'b0;
    end else begin
      state     <= state_n;
      fill_addr <= fill_addr_n;
      fill_attr <= fill_attr_n;
      we        <= we_n;
      addr_w    <= addr_n;
      d         <= d_n;
      busy      <= busy_n;
      cmd_ready <= ready_n;
    end
  end

  attr_cursor #(
    .COLS(COLS),
    .ROWS(ROWS)
  ) u_cursor (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (cur_clr),
    .inc     (cur_inc),
    .nl      (cur_nl),
    .set     (cur_set),
    .set_row (cmd_data[9:5]),
    .set_col (cmd_data[4:0]),
    .cur_addr(cur_addr)
  );

endmodule

// File: tb/tb_attr_ram_writer.sv
// Directed bench for attr_ram_writer: default 32x32 instance plus a 10x6 instance
// that exercises position clamping and non-power-of-two row arithmetic.
module tb_attr_ram_writer;
  import lcd_text_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       cmd_valid, cmd_ready, we, busy;
  logic [1:0] cmd_op;
  logic [9:0] cmd_data, addr_w;
  logic [7:0] d;

  logic       s_cmd_valid, s_cmd_ready, s_we, s_busy;
  logic [1:0] s_cmd_op;
  logic [9:0] s_cmd_data, s_addr_w;
  logic [7:0] s_d;

  int n_tests = 0;
  int n_fail  = 0;
  int bad;

  logic [7:0] mem   [1024];
  logic [7:0] s_mem [64];

  attr_ram_writer u_dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .addr_w(addr_w), .d(d), .we(we), .busy(busy)
  );

  attr_ram_writer #(.COLS(10), .ROWS(6), .INIT_ATTR(8'h5A)) u_small (
    .clk(clk), .rst_n(rst_n), .cmd_valid(s_cmd_valid), .cmd_ready(s_cmd_ready),
    .cmd_op(s_cmd_op), .cmd_data(s_cmd_data), .addr_w(s_addr_w), .d(s_d), .we(s_we),
    .busy(s_busy)
  );

  // RAM models capture writes mid-cycle, away from the DUT's active edge.
  always @(negedge clk) begin
    if (we === 1'b1) mem[addr_w] <= d;
    if (s_we === 1'b1) s_mem[s_addr_w[5:0]] <= s_d;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cmd(input logic [1:0] op, input logic [9:0] data);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic s_cmd(input logic [1:0] op, input logic [9:0] data);
    s_cmd_valid = 1'b1;
    s_cmd_op    = op;
    s_cmd_data  = data;
    @(negedge clk);
    s_cmd_valid = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    cmd_valid   = 1'b0; cmd_op   = 2'd0; cmd_data   = '0;
    s_cmd_valid = 1'b0; s_cmd_op = 2'd0; s_cmd_data = '0;
    repeat (3) @(negedge clk);

    chk("rst_outputs", {we, busy, cmd_ready, addr_w, d}, {1'b0, 1'b1, 1'b0, 10'd0, 8'h00});
    chk("rst_state", 32'(u_dut.state), 32'(INIT_FILL));
    chk("rst_cursor", {u_dut.u_cursor.row, u_dut.u_cursor.col, u_dut.cur_addr}, 20'd0);

    rst_n = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      chk("init_fill", {we, busy, cmd_ready, addr_w, d}, {1'b1, 1'b1, 1'b0, 10'(i), 8'h07});
    end
    @(negedge clk);
    chk("init_done", {we, busy, cmd_ready}, 3'b001);
    bad = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== 8'h07) bad++;
    chk("ram_init", bad, 0);

    // Small instance finished its 60-cell clear long ago.
    chk("s_idle", {s_we, s_busy, s_cmd_ready}, 3'b001);
    bad = 0;
    for (int i = 0; i < 60; i++) if (s_mem[i] !== 8'h5A) bad++;
    chk("s_ram_init", bad, 0);

    // Mid-row position, back-to-back writes cross into the next row.
    cmd(OP_SET_POS, {5'd2, 5'd31});
    chk("setpos_nowrite", we, 1'b0);
    cmd(OP_WRITE, 10'h0A1);
    chk("wr_a1", {we, addr_w, d}, {1'b1, 10'd95, 8'hA1});
    cmd(OP_WRITE, 10'h0A2);
    chk("wr_a2", {we, addr_w, d}, {1'b1, 10'd96, 8'hA2});
    @(negedge clk);
    chk("wr_idle", we, 1'b0);
    chk("cursor_3_1", {u_dut.u_cursor.row, u_dut.u_cursor.col, u_dut.cur_addr},
        {5'd3, 5'd1, 10'd97});

    // Last cell then wrap to 0.
    cmd(OP_SET_POS, {5'd31, 5'd31});
    cmd(OP_WRITE, 10'h055);
    chk("wr_last", {we, addr_w, d}, {1'b1, 10'd1023, 8'h55});
    cmd(OP_WRITE, 10'h066);
    chk("wr_wrap", {we, addr_w, d}, {1'b1, 10'd0, 8'h66});

    // Bottom row, then newline wraps to the top.
    cmd(OP_SET_POS, {5'd31, 5'd5});
    cmd(OP_WRITE, 10'h077);
    chk("wr_997", {we, addr_w, d}, {1'b1, 10'd997, 8'h77});
    cmd(OP_NEWLINE, 10'h3FF);
    chk("nl_nowrite", we, 1'b0);
    cmd(OP_WRITE, 10'h011);
    chk("nl_wrap_wr", {we, addr_w, d}, {1'b1, 10'd0, 8'h11});

    // Small instance: out-of-range position clamps to row 5, col 9.
    s_cmd(OP_SET_POS, {5'd20, 5'd25});
    s_cmd(OP_WRITE, 10'h0C1);
    chk("s_clamp_wr", {s_we, s_addr_w, s_d}, {1'b1, 10'd59, 8'hC1});
    s_cmd(OP_WRITE, 10'h0C2);
    chk("s_wrap_wr", {s_we, s_addr_w, s_d}, {1'b1, 10'd0, 8'hC2});
    s_cmd(OP_SET_POS, {5'd2, 5'd9});
    s_cmd(OP_WRITE, 10'h0D1);
    chk("s_row_end", {s_we, s_addr_w, s_d}, {1'b1, 10'd29, 8'hD1});
    s_cmd(OP_WRITE, 10'h0D2);
    chk("s_row_next", {s_we, s_addr_w, s_d}, {1'b1, 10'd30, 8'hD2});
    s_cmd(OP_SET_POS, {5'd3, 5'd4});
    s_cmd(OP_NEWLINE, 10'h000);
    s_cmd(OP_WRITE, 10'h0E1);
    chk("s_newline", {s_we, s_addr_w, s_d}, {1'b1, 10'd40, 8'hE1});

    // FILL with the host holding a WRITE pending throughout.
    cmd_valid = 1'b1; cmd_op = OP_FILL; cmd_data = 10'h03C;
    @(negedge clk);
    chk("fill_start", {we, busy, cmd_ready}, 3'b010);
    cmd_op = OP_WRITE; cmd_data = 10'h099;
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      chk("fill", {we, busy, cmd_ready, addr_w, d}, {1'b1, 1'b1, 1'b0, 10'(i), 8'h3C});
    end
    @(negedge clk);
    chk("fill_done", {we, busy, cmd_ready}, 3'b001);
    @(negedge clk);
    chk("fill_next_wr", {we, addr_w, d}, {1'b1, 10'd0, 8'h99});
    cmd_valid = 1'b0;
    @(negedge clk);
    bad = 0;
    if (mem[0] !== 8'h99) bad++;
    for (int i = 1; i < 1024; i++) if (mem[i] !== 8'h3C) bad++;
    chk("ram_fill", bad, 0);

    // Reset in the middle of a fill aborts it at once and restarts the clear.
    cmd(OP_FILL, 10'h0F0);
    repeat (501) @(negedge clk);
    chk("f0_mid", {we, addr_w, d}, {1'b1, 10'd500, 8'hF0});
    #2 rst_n = 1'b0;
    #1;
    chk("abort_async", {we, busy, cmd_ready, addr_w, d}, {1'b0, 1'b1, 1'b0, 10'd0, 8'h00});
    chk("abort_state", 32'(u_dut.state), 32'(INIT_FILL));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("restart_0", {we, busy, addr_w, d}, {1'b1, 1'b1, 10'd0, 8'h07});
    @(negedge clk);
    chk("restart_1", {we, busy, addr_w, d}, {1'b1, 1'b1, 10'd1, 8'h07});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
